keypad_scan_4x4: RTL



---
 rtl/keypad_scan_4x4.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: scanned 4x4 hex keypad controller.
// Drives one row low at a time and samples the column lines on each prescaler
// tick. Presses and releases are debounced over whole scan frames. Each accepted
// key is emitted as a 4-bit code with a one-cycle strobe and, when enabled,
// shifted into a 32-bit hex digit accumulator.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   ena          shift accepted keys into o_number
//   clr          synchronous clear of o_number (wins over a same-cycle shift)
//   i_col[3:0]   column lines, active-low, asynchronous
//   o_row[3:0]   row drive, one-cold, active-low
//   o_key[3:0]   code of the last accepted key
//   o_key_valid  one-cycle strobe per accepted key
//   o_number     hex digit accumulator, newest digit in [3:0]
//
// Build option: define KEYPAD_AUTOREPEAT_EN to re-accept a held key after
// 16 frames and then every 4 frames.

module keypad_scan_4x4 #(
    parameter int unsigned SCAN_DIV_W      = 15,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        clr,
    input  logic [3:0]  i_col,
    output logic [3:0]  o_row,
    output logic [3:0]  o_key,
    output logic        o_key_valid,
    output logic [31:0] o_number
);

    localparam int unsigned FC_W  = 4;
    localparam int unsigned KEY_W = 4;
    localparam int unsigned NUM_W = 32;
    localparam logic [FC_W-1:0] FC_DONE = FC_W'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_HELD} state_t;

    state_t               state, state_n;
    logic [FC_W-1:0]      fc, fc_n;
    logic [KEY_W-1:0]     cand, cand_n;
    logic [3:0]           col_s1, col_s2;
    logic [SCAN_DIV_W-1:0] presc;
    logic [1:0]           r;
    // Frame accumulator: hit count saturates at 2 (= MULTI), code of first hit.
    logic [1:0]           acc_cnt;
    logic [KEY_W-1:0]     acc_code;

    logic                 tick_c;
    logic                 frame_end_c;
    logic [3:0]           low_c;
    logic [2:0]           row_n_c;
    logic [1:0]           row_cnt_c;
    logic [1:0]           col_idx_c;
    logic [2:0]           sum_c;
    logic [1:0]           frame_cnt_c;
    logic [KEY_W-1:0]     frame_code_c;
    logic [FC_W-1:0]      fc_inc_c;
    logic                 accept_c;
    logic [KEY_W-1:0]     key_c;

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [4:0]           rep, rep_n;
    logic [4:0]           rep_inc_c;
`endif

    assign tick_c      = &presc;
    assign frame_end_c = tick_c && (r == 2'd3);
    assign low_c       = ~col_s2;
    assign row_n_c     = 3'(low_c[0]) + 3'(low_c[1]) + 3'(low_c[2]) + 3'(low_c[3]);
    assign row_cnt_c   = (row_n_c > 3'd1) ? 2'd2 : row_n_c[1:0];
    assign sum_c       = 3'(acc_cnt) + 3'(row_cnt_c);
    assign frame_cnt_c = (sum_c > 3'd1) ? 2'd2 : sum_c[1:0];
    assign frame_code_c = (acc_cnt == 2'd0) ? {r, col_idx_c} : acc_code;
    assign fc_inc_c    = fc + 4'd1;

    // Index of the low column; only meaningful when exactly one is low.
    always_comb begin
        col_idx_c = 2'd0;
        if (low_c[1]) col_idx_c = 2'd1;
        if (low_c[2]) col_idx_c = 2'd2;
        if (low_c[3]) col_idx_c = 2'd3;
    end

    // Column synchronizer, prescaler, row scan and per-frame hit collection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1   <= 4'b1111;
            col_s2   <= 4'b1111;
            presc    <= '0;
            r        <= 2'd0;
            o_row    <= 4'b1110;
            acc_cnt  <= 2'd0;
            acc_code <= '0;
        end else begin
            col_s1 <= i_col;
            col_s2 <= col_s1;
            presc  <= presc + SCAN_DIV_W'(1);
            if (tick_c) begin
                r     <= r + 2'd1;
                o_row <= ~(4'b0001 << 2'(r + 2'd1));
                if (r == 2'd3) begin
                    acc_cnt  <= 2'd0;
                    acc_code <= '0;
                end else begin
                    acc_cnt  <= frame_cnt_c;
                    acc_code <= frame_code_c;
                end
            end
        end
    end

    // Debounce FSM next-state logic, evaluated once per frame.
    always_comb begin
        state_n  = state;
        fc_n     = fc;
        cand_n   = cand;
        accept_c = 1'b0;
        key_c    = cand;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_n     = (state == ST_HELD) ? rep : 5'd0;
        rep_inc_c = rep + 5'd1;
`endif
        if (frame_end_c) begin
            unique case (state)
                ST_IDLE: begin
                    if (frame_cnt_c == 2'd1) begin
                        cand_n = frame_code_c;
                        key_c  = frame_code_c;
                        if (FC_DONE == 4'd1) begin
                            accept_c = 1'b1;
                            state_n  = ST_HELD;
                            fc_n     = '0;
                        end else begin
                            fc_n    = 4'd1;
                            state_n = ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (frame_cnt_c == 2'd1 && frame_code_c == cand) begin
                        if (fc_inc_c == FC_DONE) begin
                            accept_c = 1'b1;
                            state_n  = ST_HELD;
                            fc_n     = '0;
                        end else begin
                            fc_n = fc_inc_c;
                        end
                    end else begin
                        state_n = ST_IDLE;
                        fc_n    = '0;
                    end
                end
                ST_HELD: begin
                    if (frame_cnt_c == 2'd0) begin
                        if (fc_inc_c == FC_DONE) begin
                            state_n = ST_IDLE;
                            fc_n    = '0;
                        end else begin
                            fc_n = fc_inc_c;
                        end
                    end else begin
                        fc_n = '0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    // First repeat after 16 held frames, then every 4.
                    if (frame_cnt_c == 2'd1 && frame_code_c == cand) begin
                        if (rep_inc_c == 5'd16) begin
                            accept_c = 1'b1;
                            rep_n    = 5'd12;
                        end else begin
                            rep_n = rep_inc_c;
                        end
                    end else begin
                        rep_n = 5'd0;
                    end
`endif
                end
                default: begin
                    state_n = ST_IDLE;
                    fc_n    = '0;
                end
            endcase
        end
    end

    // State registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            fc          <= '0;
            cand        <= '0;
            o_key       <= '0;
            o_key_valid <= 1'b0;
            o_number    <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep         <= 5'd0;
`endif
        end else begin
            state       <= state_n;
            fc          <= fc_n;
            cand        <= cand_n;
            o_key_valid <= accept_c;
            if (accept_c) o_key <= key_c;
            if (clr) begin
                o_number <= '0;
            end else if (accept_c && ena) begin
                o_number <= {o_number[NUM_W-KEY_W-1:0], key_c};
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            rep         <= rep_n;
`endif
        end
    end

endmodule
